// File: rtl/note_voice_ctrl.sv
// -----------------------------------------------------------------------------
// note_voice_ctrl
//
// Drives one notebank voice from a stream of key events. A key press turns the
// MIDI key number into an oscillator period (octave found by repeated
// subtraction of 12, then a base-period lookup shifted by the octave) and issues
// a one-cycle note_on. A matching key release issues a one-cycle note_off, and
// the voice stays busy until the notebank reports done or a timeout expires.
//
// Ports:
//   clk        system clock (notebank clk_fast domain)
//   rst_b      asynchronous active-low reset
//   key_valid  key event present
//   key_ready  event accepted on a clk edge when key_valid & key_ready
//   key_num    MIDI key number 0..127
//   key_down   1 = press, 0 = release
//   note_on    one-cycle pulse to notebank (registered)
//   note_off   one-cycle pulse to notebank (registered)
//   period     oscillator period in clk cycles (registered)
//   done       notebank amplitude envelope finished
//   busy       voice in use (registered, state != IDLE)
//   cur_key    key currently owning the voice
//   timeout    one-cycle pulse when the done wait expires
// -----------------------------------------------------------------------------
module note_voice_ctrl #(
    parameter int PERIOD_W     = 32,
    parameter int DONE_TIMEOUT = 50000000
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [6:0]          key_num,
    input  logic                key_down,
    output logic                note_on,
    output logic                note_off,
    output logic [PERIOD_W-1:0] period,
    input  logic                done,
    output logic                busy,
    output logic [6:0]          cur_key,
    output logic                timeout
);

    localparam int CNT_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIVIDE,
        S_LOAD,
        S_HELD,
        S_RELEASE,
        S_WAIT_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          rem_q, rem_d;
    logic [3:0]          oct_q, oct_d;
    logic [6:0]          cur_key_q, cur_key_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                note_on_q, note_on_d;
    logic                note_off_q, note_off_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic [22:0]         shifted;

    // Base periods for the top octave (octave 10) at a 50 MHz clock.
    function automatic logic [12:0] base_period(input logic [3:0] idx);
        case (idx)
            4'd0:    base_period = 13'd5972;
            4'd1:    base_period = 13'd5637;
            4'd2:    base_period = 13'd5321;
            4'd3:    base_period = 13'd5022;
            4'd4:    base_period = 13'd4740;
            4'd5:    base_period = 13'd4474;
            4'd6:    base_period = 13'd4223;
            4'd7:    base_period = 13'd3986;
            4'd8:    base_period = 13'd3762;
            4'd9:    base_period = 13'd3551;
            4'd10:   base_period = 13'd3352;
            default: base_period = 13'd3164;
        endcase
    endfunction

    assign key_ready = (state_q == S_IDLE) || (state_q == S_HELD) ||
                       (state_q == S_WAIT_DONE);
    assign accept    = key_valid && key_ready;

    // Lower octaves have longer periods: shift left by (10 - octave).
    assign shifted   = 23'(base_period(rem_q[3:0])) << (4'd10 - oct_q);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        oct_d      = oct_q;
        cur_key_d  = cur_key_q;
        period_d   = period_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = cnt_q;

        // A press can only be accepted in a ready state and always wins,
        // including over a done arriving in WAIT_DONE on the same edge.
        if (accept && key_down) begin
            cur_key_d = key_num;
            rem_d     = key_num;
            oct_d     = 4'd0;
            state_d   = S_DIVIDE;
        end else begin
            case (state_q)
                S_DIVIDE: begin
                    if (rem_q >= 7'd12) begin
                        rem_d = rem_q - 7'd12;
                        oct_d = oct_q + 4'd1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    period_d  = PERIOD_W'(shifted);
                    note_on_d = 1'b1;
                    state_d   = S_HELD;
                end
                S_HELD: begin
                    // Releases of other keys are consumed without effect.
                    if (accept && (key_num == cur_key_q)) begin
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    note_off_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            oct_q      <= '0;
            cur_key_q  <= '0;
            period_q   <= '0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            oct_q      <= oct_d;
            cur_key_q  <= cur_key_d;
            period_q   <= period_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign note_on  = note_on_q;
    assign note_off = note_off_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;
    assign period   = period_q;
    assign cur_key  = cur_key_q;

endmodule

// File: tb/tb_note_voice_ctrl.sv
module tb_note_voice_ctrl;

    localparam int PW = 32;
    localparam int TO = 16;

    logic          clk       = 1'b0;
    logic          rst_b     = 1'b1;
    logic          key_valid = 1'b0;
    logic [6:0]    key_num   = 7'd0;
    logic          key_down  = 1'b0;
    logic          done      = 1'b0;
    logic          key_ready;
    logic          note_on;
    logic          note_off;
    logic [PW-1:0] period;
    logic          busy;
    logic [6:0]    cur_key;
    logic          timeout;

    note_voice_ctrl #(.PERIOD_W(PW), .DONE_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_num   (key_num),
        .key_down  (key_down),
        .note_on   (note_on),
        .note_off  (note_off),
        .period    (period),
        .done      (done),
        .busy      (busy),
        .cur_key   (cur_key),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // kind: 0 = note_on, 1 = note_off, 2 = timeout
    typedef struct {
        int     kind;
        longint per;
        int     key;
        int     cyc;
    } ev_t;

    ev_t q[$];

    int base_tbl[12] = '{5972, 5637, 5321, 5022, 4740, 4474,
                         4223, 3986, 3762, 3551, 3352, 3164};

    function automatic longint model_period(int key);
        return longint'(base_tbl[key % 12]) << (10 - key / 12);
    endfunction

    task automatic chk(string tag, longint obs, longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic take(int kind);
        ev_t e;
        chk("event_pending", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_cur_key", cur_key, e.key);
            if (kind == 0) chk("event_period", period, e.per);
        end
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_b) begin
            if (note_on)  take(0);
            if (note_off) take(1);
            if (timeout)  take(2);
        end
    end

    task automatic press(int key);
        chk("key_ready_before_press", key_ready, 1);
        key_valid = 1'b1;
        key_num   = key[6:0];
        key_down  = 1'b1;
        tick();
        key_valid = 1'b0;
        q.push_back('{0, model_period(key), key, cyc + key / 12 + 2});
    endtask

    task automatic rel_key(int key, bit exp_off, bit exp_to);
        chk("key_ready_before_release", key_ready, 1);
        key_valid = 1'b1;
        key_num   = key[6:0];
        key_down  = 1'b0;
        tick();
        key_valid = 1'b0;
        if (exp_off) q.push_back('{1, 0, key, cyc + 1});
        if (exp_to)  q.push_back('{2, 0, key, cyc + 1 + TO});
    endtask

    initial begin
        // Reset state
        #2 rst_b = 1'b0;
        tick(3);
        chk("rst_note_on", note_on, 0);
        chk("rst_note_off", note_off, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_period", period, 0);
        chk("rst_cur_key", cur_key, 0);
        rst_b = 1'b1;
        tick();
        chk("idle_key_ready", key_ready, 1);
        chk("idle_busy", busy, 0);

        // Key 69: octave 5, index 9
        press(69);
        chk("k69_ready_low", key_ready, 0);
        chk("k69_busy", busy, 1);
        chk("k69_cur_key", cur_key, 69);
        tick(8);
        chk("k69_period", period, 113632);
        chk("k69_held_ready", key_ready, 1);
        chk("k69_held_busy", busy, 1);

        // Extremes of the key range, retriggered from HELD
        press(0);
        tick(4);
        chk("k0_period", period, 6115328);
        press(127);
        tick(14);
        chk("k127_period", period, model_period(127));
        chk("k127_cur_key", cur_key, 127);

        // Mismatched release is ignored; matching release then done
        press(60);
        tick(8);
        rel_key(61, 1'b0, 1'b0);
        tick(3);
        chk("wrong_rel_busy", busy, 1);
        chk("wrong_rel_ready", key_ready, 1);
        chk("wrong_rel_cur_key", cur_key, 60);
        rel_key(60, 1'b1, 1'b0);
        tick(5);
        chk("wait_done_busy", busy, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("after_done_busy", busy, 0);
        chk("after_done_ready", key_ready, 1);

        // done while HELD is ignored; retrigger 60 -> 64 without note_off
        press(60);
        tick(8);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("held_done_ignored", busy, 1);
        press(64);
        tick(8);
        chk("k64_period", period, 151680);
        chk("k64_cur_key", cur_key, 64);

        // Release with no done: timeout expires
        rel_key(64, 1'b1, 1'b1);
        tick(20);
        chk("timeout_busy", busy, 0);
        chk("timeout_ready", key_ready, 1);

        // Press and done on the same edge in WAIT_DONE: press wins
        press(5);
        tick(4);
        rel_key(5, 1'b1, 1'b0);
        tick(3);
        done = 1'b1;
        press(7);
        done = 1'b0;
        chk("press_wins_busy", busy, 1);
        chk("press_wins_ready", key_ready, 0);
        tick(4);
        chk("press_wins_cur_key", cur_key, 7);
        chk("press_wins_period", period, model_period(7));

        // Reset asserted mid-DIVIDE drops the pending note_on
        press(100);
        tick(3);
        rst_b = 1'b0;
        #1;
        void'(q.pop_back());
        chk("midrst_note_on", note_on, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_period", period, 0);
        chk("midrst_cur_key", cur_key, 0);
        tick(2);
        rst_b = 1'b1;
        tick(15);
        chk("postrst_busy", busy, 0);
        chk("postrst_ready", key_ready, 1);
        chk("postrst_period", period, 0);

        tick(3);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
